// File: rtl/edge_detect_multi.sv
// Multi-channel edge detector: per-channel input synchroniser, persistence
// filter, edge qualification by mode, sticky pending flags and an irq output.
module edge_detect_multi #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     sig_in,
  input  logic [2*WIDTH-1:0]   mode,
  input  logic [WIDTH-1:0]     clr,
  output logic [WIDTH-1:0]     level,
  output logic [WIDTH-1:0]     pulse,
  output logic [WIDTH-1:0]     pending,
  output logic                 irq
);

  localparam int unsigned     CW      = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0]   CNT_MAX = CW'(FILTER_LEN - 1);

  logic [WIDTH-1:0] sync_w;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign sync_w = sig_in;
    end else begin : g_sync
      logic [WIDTH-1:0] sync_q [SYNC_STAGES];

      // Shift raw inputs through the synchroniser chain
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int unsigned s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
        end else begin
          sync_q[0] <= sig_in;
          for (int unsigned s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
      end

      assign sync_w = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  logic [WIDTH-1:0] level_q, level_d;
  logic [WIDTH-1:0] pulse_q, pulse_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic             irq_q;

  // Persistence filter, edge qualification and pending set/clear per channel
  always_comb begin
    level_d = level_q;
    pulse_d = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync_w[i] != level_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          level_d[i] = ~level_q[i];
          case (mode[2*i +: 2])
            2'b01:   pulse_d[i] = ~level_q[i];
            2'b10:   pulse_d[i] = level_q[i];
            2'b11:   pulse_d[i] = 1'b1;
            default: pulse_d[i] = 1'b0;
          endcase
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
    // A new event in the same cycle as clr keeps the flag set
    pending_d = pulse_d | (pending_q & ~clr);
  end

  // Filter counters and channel state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
      level_q   <= '0;
      pulse_q   <= '0;
      pending_q <= '0;
    end else begin
      for (int unsigned i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
      level_q   <= level_d;
      pulse_q   <= pulse_d;
      pending_q <= pending_d;
    end
  end

  // Interrupt follows the registered pending flags one cycle later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_q <= 1'b0;
    else        irq_q <= |pending_q;
  end

  assign level   = level_q;
  assign pulse   = pulse_q;
  assign pending = pending_q;
  assign irq     = irq_q;

endmodule

// File: tb/tb_edge_detect_multi.sv
// Bench for edge_detect_multi: hand-derived per-edge expectations are queued
// when stimulus is applied and compared as each clock edge completes.
module tb_edge_detect_multi;

  logic        clk;
  logic        rst_n;
  logic [7:0]  sig, clr, level, pulse, pending;
  logic [15:0] mode;
  logic        irq;
  logic [7:0]  sig_b, clr_b, level_b, pulse_b, pending_b;
  logic [15:0] mode_b;
  logic        irq_b;

  edge_detect_multi #(.WIDTH(8), .SYNC_STAGES(2), .FILTER_LEN(4)) dut (
    .clk(clk), .rst_n(rst_n), .sig_in(sig), .mode(mode), .clr(clr),
    .level(level), .pulse(pulse), .pending(pending), .irq(irq));

  edge_detect_multi #(.WIDTH(8), .SYNC_STAGES(0), .FILTER_LEN(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_b), .mode(mode_b), .clr(clr_b),
    .level(level_b), .pulse(pulse_b), .pending(pending_b), .irq(irq_b));

  typedef struct {
    int unsigned cyc;
    int          kind;
    int          ch;
    logic        val;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int unsigned edge_n  = 0;
  logic        obs;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  function automatic void push(int unsigned cyc, int kind, int ch, logic v, string tag);
    exp_t e;
    e.cyc = cyc; e.kind = kind; e.ch = ch; e.val = v; e.tag = tag;
    sb.push_back(e);
  endfunction

  function automatic logic probe(int kind, int ch);
    case (kind)
      0:       return level[ch];
      1:       return pulse[ch];
      2:       return pending[ch];
      3:       return irq;
      4:       return level_b[ch];
      5:       return pulse_b[ch];
      default: return pending_b[ch];
    endcase
  endfunction

  task automatic idle_clear();
    clr = '1; clr_b = '1;
    @(posedge clk); #1;
    clr = '0; clr_b = '0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({level, pulse, pending, irq} !== 25'd0) begin
      n_fail++;
      $display("FAIL reset_a: observed %h, expected 0", {level, pulse, pending, irq});
    end
    n_tests++;
    if ({level_b, pulse_b, pending_b, irq_b} !== 25'd0) begin
      n_fail++;
      $display("FAIL reset_b: observed %h, expected 0", {level_b, pulse_b, pending_b, irq_b});
    end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_rising();
    int unsigned base;
    mode[1:0] = 2'b01;
    base = edge_n;
    for (int unsigned c = base + 1; c <= base + 10; c++) begin
      push(c, 1, 0, c == base + 6, "rise_pulse0");
      push(c, 0, 0, c >= base + 6, "rise_level0");
      push(c, 2, 0, c >= base + 6, "rise_pending0");
      push(c, 3, 0, c >= base + 7, "rise_irq");
    end
    sig[0] = 1'b1;
    for (int t = 0; t < 10; t++) begin
      @(posedge clk); #1;
      for (int j = int'(sb.size()) - 1; j >= 0; j--) begin
        if (sb[j].cyc == edge_n) begin
          obs = probe(sb[j].kind, sb[j].ch);
          n_tests++;
          if (obs !== sb[j].val) begin
            n_fail++;
            $display("FAIL %s @edge %0d: observed %b, expected %b", sb[j].tag, edge_n, obs, sb[j].val);
          end
          sb.delete(j);
        end
      end
    end
    idle_clear();
  endtask

  task automatic test_glitch();
    int unsigned base;
    mode[3:2] = 2'b11;
    for (int r = 0; r < 2; r++) begin
      base = edge_n;
      for (int unsigned c = base + 1; c <= base + 14; c++) begin
        if (r == 0) begin
          push(c, 0, 1, 1'b0, "glitch3_level1");
          push(c, 1, 1, 1'b0, "glitch3_pulse1");
          push(c, 2, 1, 1'b0, "glitch3_pending1");
        end else begin
          push(c, 0, 1, (c >= base + 6) && (c < base + 10), "hold4_level1");
          push(c, 1, 1, (c == base + 6) || (c == base + 10), "hold4_pulse1");
          push(c, 2, 1, c >= base + 6, "hold4_pending1");
          push(c, 3, 0, c >= base + 7, "hold4_irq");
        end
      end
      for (int t = 0; t < 14; t++) begin
        if (t == 0) sig[1] = 1'b1;
        if (t == 3 + r) sig[1] = 1'b0;
        @(posedge clk); #1;
        for (int j = int'(sb.size()) - 1; j >= 0; j--) begin
          if (sb[j].cyc == edge_n) begin
            obs = probe(sb[j].kind, sb[j].ch);
            n_tests++;
            if (obs !== sb[j].val) begin
              n_fail++;
              $display("FAIL %s @edge %0d: observed %b, expected %b", sb[j].tag, edge_n, obs, sb[j].val);
            end
            sb.delete(j);
          end
        end
      end
    end
    idle_clear();
  endtask

  task automatic test_mode();
    int unsigned base;
    for (int r = 0; r < 2; r++) begin
      mode[5:4] = (r == 0) ? 2'b10 : 2'b11;
      base = edge_n;
      for (int unsigned c = base + 1; c <= base + 20; c++) begin
        push(c, 0, 2, (c >= base + 6) && (c < base + 16), "mode_level2");
        push(c, 1, 2, (r == 0) ? (c == base + 16) : ((c == base + 6) || (c == base + 16)), "mode_pulse2");
        push(c, 2, 2, (r == 0) ? (c >= base + 16) : 1'b1, "mode_pending2");
        push(c, 3, 0, (r == 0) ? (c >= base + 17) : 1'b1, "mode_irq");
      end
      for (int t = 0; t < 20; t++) begin
        if (t == 0)  sig[2] = 1'b1;
        if (t == 10) sig[2] = 1'b0;
        @(posedge clk); #1;
        for (int j = int'(sb.size()) - 1; j >= 0; j--) begin
          if (sb[j].cyc == edge_n) begin
            obs = probe(sb[j].kind, sb[j].ch);
            n_tests++;
            if (obs !== sb[j].val) begin
              n_fail++;
              $display("FAIL %s @edge %0d: observed %b, expected %b", sb[j].tag, edge_n, obs, sb[j].val);
            end
            sb.delete(j);
          end
        end
      end
    end
    mode[5:4] = 2'b00;
    base = edge_n;
    for (int unsigned c = base + 1; c <= base + 8; c++) begin
      push(c, 0, 2, c >= base + 6, "off_level2");
      push(c, 1, 2, 1'b0, "off_pulse2");
      push(c, 2, 2, 1'b1, "off_pending2");
      push(c, 3, 0, 1'b1, "off_irq");
    end
    for (int t = 0; t < 8; t++) begin
      if (t == 0) sig[2] = 1'b1;
      @(posedge clk); #1;
      for (int j = int'(sb.size()) - 1; j >= 0; j--) begin
        if (sb[j].cyc == edge_n) begin
          obs = probe(sb[j].kind, sb[j].ch);
          n_tests++;
          if (obs !== sb[j].val) begin
            n_fail++;
            $display("FAIL %s @edge %0d: observed %b, expected %b", sb[j].tag, edge_n, obs, sb[j].val);
          end
          sb.delete(j);
        end
      end
    end
    idle_clear();
  endtask

  task automatic test_clr_collide();
    int unsigned base;
    mode[7:6] = 2'b11;
    base = edge_n;
    for (int unsigned c = base + 1; c <= base + 20; c++) begin
      push(c, 0, 3, (c >= base + 6) && (c < base + 12), "clr_level3");
      push(c, 1, 3, (c == base + 6) || (c == base + 12), "clr_pulse3");
      push(c, 2, 3, (c >= base + 6) && (c <= base + 15), "clr_pending3");
      push(c, 3, 0, (c >= base + 7) && (c <= base + 16), "clr_irq");
    end
    for (int t = 0; t < 20; t++) begin
      if (t == 0)  sig[3] = 1'b1;
      if (t == 6)  sig[3] = 1'b0;
      if (t == 11) clr[3] = 1'b1;
      if (t == 12) clr[3] = 1'b0;
      if (t == 15) clr[3] = 1'b1;
      if (t == 19) clr[3] = 1'b0;
      @(posedge clk); #1;
      for (int j = int'(sb.size()) - 1; j >= 0; j--) begin
        if (sb[j].cyc == edge_n) begin
          obs = probe(sb[j].kind, sb[j].ch);
          n_tests++;
          if (obs !== sb[j].val) begin
            n_fail++;
            $display("FAIL %s @edge %0d: observed %b, expected %b", sb[j].tag, edge_n, obs, sb[j].val);
          end
          sb.delete(j);
        end
      end
    end
    idle_clear();
  endtask

  task automatic test_reset_mid();
    int unsigned base;
    mode[9:8] = 2'b01;
    sig[4] = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({level, pulse, pending, irq} !== 25'd0) begin
      n_fail++;
      $display("FAIL midreset_a: observed %h, expected 0", {level, pulse, pending, irq});
    end
    n_tests++;
    if ({level_b, pulse_b, pending_b, irq_b} !== 25'd0) begin
      n_fail++;
      $display("FAIL midreset_b: observed %h, expected 0", {level_b, pulse_b, pending_b, irq_b});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    base = edge_n;
    for (int unsigned c = base + 1; c <= base + 10; c++) begin
      push(c, 0, 4, c >= base + 6, "rel_level4");
      push(c, 1, 4, c == base + 6, "rel_pulse4");
      push(c, 2, 4, c >= base + 6, "rel_pending4");
      push(c, 1, 0, c == base + 6, "rel_pulse0");
      push(c, 0, 2, c >= base + 6, "rel_level2");
      push(c, 1, 2, 1'b0, "rel_pulse2");
      push(c, 3, 0, c >= base + 7, "rel_irq");
    end
    for (int t = 0; t < 10; t++) begin
      @(posedge clk); #1;
      for (int j = int'(sb.size()) - 1; j >= 0; j--) begin
        if (sb[j].cyc == edge_n) begin
          obs = probe(sb[j].kind, sb[j].ch);
          n_tests++;
          if (obs !== sb[j].val) begin
            n_fail++;
            $display("FAIL %s @edge %0d: observed %b, expected %b", sb[j].tag, edge_n, obs, sb[j].val);
          end
          sb.delete(j);
        end
      end
    end
    idle_clear();
  endtask

  task automatic test_back_to_back();
    int unsigned base;
    mode_b[11:10] = 2'b11;
    base = edge_n;
    for (int unsigned t = 0; t < 12; t++) begin
      push(base + t + 1, 4, 5, (t % 2) == 0, "fast_level5");
      push(base + t + 1, 5, 5, 1'b1, "fast_pulse5");
      push(base + t + 1, 6, 5, 1'b1, "fast_pending5");
    end
    push(base + 13, 4, 5, 1'b0, "fast_level5_idle");
    push(base + 13, 5, 5, 1'b0, "fast_pulse5_idle");
    for (int t = 0; t < 13; t++) begin
      if (t < 12) sig_b[5] = ~sig_b[5];
      @(posedge clk); #1;
      for (int j = int'(sb.size()) - 1; j >= 0; j--) begin
        if (sb[j].cyc == edge_n) begin
          obs = probe(sb[j].kind, sb[j].ch);
          n_tests++;
          if (obs !== sb[j].val) begin
            n_fail++;
            $display("FAIL %s @edge %0d: observed %b, expected %b", sb[j].tag, edge_n, obs, sb[j].val);
          end
          sb.delete(j);
        end
      end
    end
    idle_clear();
  endtask

  initial begin
    rst_n = 1'b0;
    sig = '0; clr = '0; mode = '0;
    sig_b = '0; clr_b = '0; mode_b = '0;
    test_reset();
    test_rising();
    test_glitch();
    test_mode();
    test_clr_collide();
    test_reset_mid();
    test_back_to_back();
    if (sb.size() != 0) begin
      n_tests += sb.size();
      n_fail  += sb.size();
      $display("FAIL scoreboard_unchecked: observed %0d entries left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
